// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared widths, execute opcodes and issue-entry layout for the execute stage
package ex_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int OP_W  = 5;

  typedef enum logic [OP_W-1:0] {
    EX_ADD  = 5'd0,
    EX_SUB  = 5'd1,
    EX_SLL  = 5'd2,
    EX_SLT  = 5'd3,
    EX_SLTU = 5'd4,
    EX_XOR  = 5'd5,
    EX_SRL  = 5'd6,
    EX_SRA  = 5'd7,
    EX_OR   = 5'd8,
    EX_AND  = 5'd9
  } ex_op_e;

  typedef struct packed {
    ex_op_e             op;
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic [REG_W-1:0]   rs1_idx;
    logic [REG_W-1:0]   rs2_idx;
    logic               use_imm;
    logic [REG_W-1:0]   rd;
  } ex_issue_t;

endpackage

// File: rtl/ex_fwd_match.sv
// rtl/ex_fwd_match.sv - writeback-forward compare and operand select
module ex_fwd_match #(
  parameter int W     = 32,
  parameter int IDX_W = 5
) (
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  input  logic [W-1:0]     cur,
  input  logic             fwd_valid,
  input  logic [IDX_W-1:0] fwd_rd,
  input  logic [W-1:0]     fwd_data,
  output logic [W-1:0]     res
);

  logic hit;

  // x0 is hardwired zero, so a writeback to it must never be picked up
  assign hit = en & fwd_valid & (fwd_rd == idx) & (idx != '0);
  assign res = hit ? fwd_data : cur;

endmodule

// File: rtl/ex_issue_buffer.sv
// rtl/ex_issue_buffer.sv - two-entry skid buffer between decode and execute with operand snooping
module ex_issue_buffer
  import ex_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_W-1:0]  in_rs1_idx,
  input  logic [REG_W-1:0]  in_rs2_idx,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic [REG_W-1:0]  in_rd_idx,
  input  logic              fwd_valid,
  input  logic [REG_W-1:0]  fwd_rd,
  input  logic [XLEN-1:0]   fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [XLEN-1:0]   out_a,
  output logic [XLEN-1:0]   out_b,
  output logic [REG_W-1:0]  out_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  ex_issue_t       head, skid, cap, head_snp, skid_snp;
  logic            head_valid, skid_valid;
  logic [XLEN-1:0] cap_a, cap_b, head_a, head_b, skid_a, skid_b;
  logic            accept, pop;

  ex_fwd_match #(.W(XLEN), .IDX_W(REG_W)) u_cap_a (
    .en(1'b1), .idx(in_rs1_idx), .cur(in_rs1_val),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .res(cap_a));

  ex_fwd_match #(.W(XLEN), .IDX_W(REG_W)) u_cap_b (
    .en(~in_use_imm), .idx(in_rs2_idx), .cur(in_use_imm ? in_imm : in_rs2_val),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .res(cap_b));

  ex_fwd_match #(.W(XLEN), .IDX_W(REG_W)) u_head_a (
    .en(head_valid), .idx(head.rs1_idx), .cur(head.a),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .res(head_a));

  ex_fwd_match #(.W(XLEN), .IDX_W(REG_W)) u_head_b (
    .en(head_valid & ~head.use_imm), .idx(head.rs2_idx), .cur(head.b),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .res(head_b));

  ex_fwd_match #(.W(XLEN), .IDX_W(REG_W)) u_skid_a (
    .en(skid_valid), .idx(skid.rs1_idx), .cur(skid.a),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .res(skid_a));

  ex_fwd_match #(.W(XLEN), .IDX_W(REG_W)) u_skid_b (
    .en(skid_valid & ~skid.use_imm), .idx(skid.rs2_idx), .cur(skid.b),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .res(skid_b));

  always_comb begin
    cap         = '0;
    cap.op      = ex_op_e'(in_op);
    cap.a       = cap_a;
    cap.b       = cap_b;
    cap.rs1_idx = in_rs1_idx;
    cap.rs2_idx = in_rs2_idx;
    cap.use_imm = in_use_imm;
    cap.rd      = in_rd_idx;
  end

  always_comb begin
    head_snp   = head;
    head_snp.a = head_a;
    head_snp.b = head_b;
    skid_snp   = skid;
    skid_snp.a = skid_a;
    skid_snp.b = skid_b;
  end

  // in_ready depends only on registered skid state, keeping out_ready off the decode path
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready & ~flush;
  assign pop      = head_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head       <= '0;
      skid       <= '0;
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (!head_valid || pop) begin
        if (skid_valid) begin
          head       <= skid_snp;
          head_valid <= 1'b1;
        end else if (accept) begin
          head       <= cap;
          head_valid <= 1'b1;
        end else begin
          head_valid <= 1'b0;
        end
      end else begin
        head <= head_snp;
      end

      if (skid_valid) begin
        if (pop) skid_valid <= 1'b0;
        else     skid       <= skid_snp;
      end else if (accept && head_valid && !pop) begin
        skid       <= cap;
        skid_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (head_valid && !out_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign out_valid = head_valid;
  assign out_op    = head.op;
  assign out_a     = head.a;
  assign out_b     = head.b;
  assign out_rd    = head.rd;

endmodule
